draw_datapath: RTL and testbench
================================

# draw_datapath

Responder end of the drawing instruction handshake. It accepts one 32-bit instruction per `start`/`finished` transaction from a drawing sequencer, such as the background filler. It executes the instruction as a series of single-pixel writes on the VGA adapter write port, then returns a 32-bit result. It sits between the drawing sequencers (via an arbiter) and the VGA adapter.

## Interface
- `SCREEN_WIDTH`, 160, pixel columns; valid x is 0..159.
- `SCREEN_HEIGHT`, 120, pixel rows; valid y is 0..119.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  request from the initiator; held high for 2 consecutive cycles per transaction.
- `instruction`  in  32  fields:
  - [31:28] opcode
  - [27:19] arg
  - [18] plot
  - [17:15] colour
  - [14:8] y
  - [7:0] x
- `finished`  out  1  high when idle or done; low while busy.
- `result`  out  32  valid whenever `finished`=1; held until the next accept.
- `vga_x`  out  8  pixel x.
- `vga_y`  out  7  pixel y.
- `vga_colour`  out  3  pixel colour.
- `vga_plot`  out  1  write strobe; one pixel written per high cycle.

## Operation
- Opcodes:
  - 0 NOP: no writes; result 0.
  - 1 PLOT: one pixel at (x,y); result = pixels written (0 or 1).
  - 2 HLINE: `arg` pixels starting at (x,y), x incrementing; result = pixels written.
  - 3..15 illegal: no writes; result 32'hFFFF_FFFF.
- Clipping:
  - A pixel with x ≥ SCREEN_WIDTH or y ≥ SCREEN_HEIGHT is never written.
  - HLINE stops at x = SCREEN_WIDTH-1 and does not wrap to the next row.
  - HLINE with `arg`=0 writes nothing; result 0.
- `plot`=0 (dry run): all counting and result behaviour is unchanged, but `vga_plot` stays 0.
- Result is the pixel count zero-extended to 32 bits; the count fits in 9 bits.
- States:
  - IDLE: `finished`=1. If `start`=1 and armed, latch `instruction` and go to DECODE; else stay.
  - DECODE: `finished`=0; decode the latched fields and clip. Go to WRITE if at least one pixel, else DONE.
  - WRITE: `finished`=0; one pixel per cycle; go to DONE after the last pixel.
  - DONE: `finished`=1, `result` valid; go to IDLE next cycle.
- Arming (re-trigger guard):
  - After an accept, `start` must be sampled low at least once before another accept.
  - This ensures the second high cycle of the initiator's start pulse never launches a second transaction, even when NOP completes while `start` is still high.
- While busy, `start` and `instruction` are ignored; the latched copy is used.

## Timing
- Reset values:
  - state IDLE
  - `finished`=1
  - `result`=0
  - `vga_x`=0, `vga_y`=0, `vga_colour`=0, `vga_plot`=0
  - armed=1
- Accept at edge E (`start` high, IDLE, armed). `finished` is low for the cycle after E, which precedes the initiator's wait-state sample at E+2.
- PLOT latency: `vga_plot` is high in cycle E+2; `finished`=1 from E+3.
- N-pixel HLINE: `vga_plot` is high in cycles E+2..E+N+1; `finished`=1 from E+N+2.
- Zero-write instructions: `finished`=1 from E+2.
- `vga_*` are registered. `vga_x`/`vga_y`/`vga_colour` are stable in every cycle `vga_plot`=1.
- `result` changes only on the transition into DONE.
- Reset mid-operation: immediate return to reset values. The remaining pixels are abandoned and no further `vga_plot` is issued.

## Structure
- Shared `constants.h`:
  - opcode width and values
  - field bit positions
  - `X_COORD_WIDTH`=8, `Y_COORD_WIDTH`=7, `COLOUR_WIDTH`=3
  - `INSTRUCTION_WIDTH`=32, `RESULT_WIDTH`=32
  - screen size
  - state encodings
- Sub-module `dp_instr_decode` (combinational): splits the latched instruction into fields and computes the clipped pixel count for DECODE.
- `draw_datapath` holds the FSM, the x counter, the pixel counter and the arming flag.

## Test plan
- Reset, then idle for 5 cycles → `finished`=1, `result`=0, `vga_plot` never asserted.
- PLOT at x=5, y=7, colour 3'b111, plot=1, start high for 2 cycles → exactly one `vga_plot` cycle at (5,7,7) at E+2; `finished` at E+3; `result`=1.
- HLINE at x=155, y=0, arg=10 → 5 writes at x=155..159, no write at row 1, `result`=5.
- NOP with start held for 2 cycles → exactly one transaction and `result`=0. Another instruction is accepted only after `start` has been low.
- Opcode 4'd9, then PLOT at x=200 → first `result`=32'hFFFF_FFFF, second `result`=0; no `vga_plot` in either case.
- HLINE with arg=100, reset asserted at E+20 → `vga_plot`=0 from the reset edge onward, `finished`=1, and the next PLOT executes normally.

Source files
------------

// File: rtl/draw_datapath_pkg.sv
// Shared constants for the drawing datapath: instruction field layout, screen
// size, opcode values and FSM state encodings.
package draw_datapath_pkg;

   localparam int INSTRUCTION_WIDTH = 32;
   localparam int RESULT_WIDTH      = 32;
   localparam int X_COORD_WIDTH     = 8;
   localparam int Y_COORD_WIDTH     = 7;
   localparam int COLOUR_WIDTH      = 3;
   localparam int OPCODE_WIDTH      = 4;
   localparam int ARG_WIDTH         = 9;
   localparam int COUNT_WIDTH       = 9;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 28;
   localparam int ARG_MSB    = 27;
   localparam int ARG_LSB    = 19;
   localparam int PLOT_BIT   = 18;
   localparam int COLOUR_MSB = 17;
   localparam int COLOUR_LSB = 15;
   localparam int Y_MSB      = 14;
   localparam int Y_LSB      = 8;
   localparam int X_MSB      = 7;
   localparam int X_LSB      = 0;

   localparam logic [8:0] SCREEN_WIDTH  = 9'd160;
   localparam logic [7:0] SCREEN_HEIGHT = 8'd120;

   localparam logic [RESULT_WIDTH-1:0] RESULT_ILLEGAL = 32'hFFFF_FFFF;

   typedef enum logic [OPCODE_WIDTH-1:0] {
      OP_NOP   = 4'd0,
      OP_PLOT  = 4'd1,
      OP_HLINE = 4'd2
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_WRITE  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic logic [COUNT_WIDTH-1:0] min_count(input logic [COUNT_WIDTH-1:0] a,
                                                        input logic [COUNT_WIDTH-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/draw_datapath_if.sv
// Drawing instruction handshake between a sequencer (master) and the datapath (slave).
interface draw_datapath_if;
   import draw_datapath_pkg::*;

   logic                         start;
   logic [INSTRUCTION_WIDTH-1:0] instruction;
   logic                         finished;
   logic [RESULT_WIDTH-1:0]      result;

   modport master (output start, output instruction, input finished, input result);
   modport slave  (input start, input instruction, output finished, output result);

endinterface

// File: rtl/draw_datapath_decode.sv
// Splits a latched drawing instruction into fields and computes how many
// pixels survive clipping against the screen edges.
module dp_instr_decode
   import draw_datapath_pkg::*;
(
   input  logic [INSTRUCTION_WIDTH-1:0] instr_i,
   output logic [X_COORD_WIDTH-1:0]     x_o,
   output logic [Y_COORD_WIDTH-1:0]     y_o,
   output logic [COLOUR_WIDTH-1:0]      colour_o,
   output logic                         plot_o,
   output logic [COUNT_WIDTH-1:0]       count_o,
   output logic                         illegal_o
);

   logic [ARG_WIDTH-1:0]   arg_s;
   logic [COUNT_WIDTH-1:0] room_s;
   logic                   in_bounds_s;

   // Field extraction and clipped pixel count.
   always_comb begin
      x_o         = instr_i[X_MSB:X_LSB];
      y_o         = instr_i[Y_MSB:Y_LSB];
      colour_o    = instr_i[COLOUR_MSB:COLOUR_LSB];
      plot_o      = instr_i[PLOT_BIT];
      arg_s       = instr_i[ARG_MSB:ARG_LSB];
      in_bounds_s = ({1'b0, x_o} < SCREEN_WIDTH) && ({1'b0, y_o} < SCREEN_HEIGHT);
      // Columns left before the right edge; a line never wraps to the next row.
      room_s      = SCREEN_WIDTH - {1'b0, x_o};
      count_o     = 9'd0;
      illegal_o   = 1'b0;
      case (instr_i[OPCODE_MSB:OPCODE_LSB])
         OP_NOP: begin
            count_o = 9'd0;
         end
         OP_PLOT: begin
            if (in_bounds_s) begin
               count_o = 9'd1;
            end else begin
               count_o = 9'd0;
            end
         end
         OP_HLINE: begin
            if (in_bounds_s) begin
               count_o = min_count(arg_s, room_s);
            end else begin
               count_o = 9'd0;
            end
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/draw_datapath.sv
// Responder for drawing instructions: latches one instruction per handshake,
// emits the clipped pixel writes on the VGA port and reports the pixel count.
module draw_datapath
   import draw_datapath_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset,
   draw_datapath_if.slave           bus,
   output logic [X_COORD_WIDTH-1:0] vga_x,
   output logic [Y_COORD_WIDTH-1:0] vga_y,
   output logic [COLOUR_WIDTH-1:0]  vga_colour,
   output logic                     vga_plot
);

   state_e                       state_q, state_d;
   logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
   logic [COUNT_WIDTH-1:0]       remaining_q, remaining_d;
   logic                         armed_q, armed_d;
   logic                         finished_q, finished_d;
   logic [RESULT_WIDTH-1:0]      result_q, result_d;
   logic [X_COORD_WIDTH-1:0]     vga_x_q, vga_x_d;
   logic [Y_COORD_WIDTH-1:0]     vga_y_q, vga_y_d;
   logic [COLOUR_WIDTH-1:0]      vga_colour_q, vga_colour_d;
   logic                         vga_plot_q, vga_plot_d;

   logic [X_COORD_WIDTH-1:0]     dec_x_s;
   logic [Y_COORD_WIDTH-1:0]     dec_y_s;
   logic [COLOUR_WIDTH-1:0]      dec_colour_s;
   logic                         dec_plot_s;
   logic [COUNT_WIDTH-1:0]       dec_count_s;
   logic                         dec_illegal_s;

   dp_instr_decode u_decode (
      .instr_i   (instr_q),
      .x_o       (dec_x_s),
      .y_o       (dec_y_s),
      .colour_o  (dec_colour_s),
      .plot_o    (dec_plot_s),
      .count_o   (dec_count_s),
      .illegal_o (dec_illegal_s)
   );

   // State, counters and all outputs register here.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         instr_q      <= 32'd0;
         remaining_q  <= 9'd0;
         armed_q      <= 1'b1;
         finished_q   <= 1'b1;
         result_q     <= 32'd0;
         vga_x_q      <= 8'd0;
         vga_y_q      <= 7'd0;
         vga_colour_q <= 3'd0;
         vga_plot_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         instr_q      <= instr_d;
         remaining_q  <= remaining_d;
         armed_q      <= armed_d;
         finished_q   <= finished_d;
         result_q     <= result_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_plot_q   <= vga_plot_d;
      end
   end

   // Next-state logic; vga_x doubles as the running x counter during a line.
   always_comb begin
      state_d      = state_q;
      instr_d      = instr_q;
      remaining_d  = remaining_q;
      result_d     = result_q;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      vga_plot_d   = 1'b0;
      // Seeing start low re-arms; the accept below overrides this.
      if (bus.start) begin
         armed_d = armed_q;
      end else begin
         armed_d = 1'b1;
      end
      case (state_q)
         ST_IDLE: begin
            if (bus.start && armed_q) begin
               instr_d = bus.instruction;
               armed_d = 1'b0;
               state_d = ST_DECODE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DECODE: begin
            if (dec_count_s != 9'd0) begin
               state_d      = ST_WRITE;
               vga_x_d      = dec_x_s;
               vga_y_d      = dec_y_s;
               vga_colour_d = dec_colour_s;
               vga_plot_d   = dec_plot_s;
               remaining_d  = dec_count_s - 9'd1;
            end else begin
               state_d = ST_DONE;
               if (dec_illegal_s) begin
                  result_d = RESULT_ILLEGAL;
               end else begin
                  result_d = {23'd0, dec_count_s};
               end
            end
         end
         ST_WRITE: begin
            if (remaining_q != 9'd0) begin
               vga_x_d     = vga_x_q + 8'd1;
               vga_plot_d  = dec_plot_s;
               remaining_d = remaining_q - 9'd1;
            end else begin
               state_d  = ST_DONE;
               result_d = {23'd0, dec_count_s};
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      finished_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
   end

   assign bus.finished = finished_q;
   assign bus.result   = result_q;
   assign vga_x        = vga_x_q;
   assign vga_y        = vga_y_q;
   assign vga_colour   = vga_colour_q;
   assign vga_plot     = vga_plot_q;

endmodule

// File: tb/tb_draw_datapath.sv
// Scoreboard bench for draw_datapath: the driver queues expected pixels and
// results with their cycle numbers, a monitor checks whatever the DUT presents.
module tb_draw_datapath;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      int         cyc;
   } pix_t;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } res_t;

   logic       clk;
   logic       reset;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   int   cyc;
   int   checks;
   int   errors;
   logic prev_fin;
   pix_t pix_q[$];
   res_t res_q[$];

   draw_datapath_if bus ();

   draw_datapath dut (
      .clock      (clk),
      .reset      (reset),
      .bus        (bus),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mk(input int op, input int arg, input int plot,
                                      input int col, input int y, input int x);
      logic [31:0] w;
      w = {op[3:0], arg[8:0], plot[0], col[2:0], y[6:0], x[7:0]};
      return w;
   endfunction

   // Monitor: every plot strobe and every rise of finished is scored.
   always begin
      pix_t p;
      res_t r;
      @(posedge clk);
      #1;
      if (!reset) begin
         if (vga_plot) begin
            checks++;
            if (pix_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_plot cyc=%0d got (%0d,%0d,%0d)", cyc, vga_x, vga_y, vga_colour);
            end else begin
               p = pix_q.pop_front();
               if (vga_x !== p.x || vga_y !== p.y || vga_colour !== p.c || cyc != p.cyc) begin
                  errors++;
                  $display("FAIL pixel got (%0d,%0d,%0d)@%0d expected (%0d,%0d,%0d)@%0d",
                           vga_x, vga_y, vga_colour, cyc, p.x, p.y, p.c, p.cyc);
               end
            end
         end
         if (bus.finished && !prev_fin) begin
            checks++;
            if (res_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done cyc=%0d result=%h", cyc, bus.result);
            end else begin
               r = res_q.pop_front();
               if (bus.result !== r.res || cyc != r.cyc || pix_q.size() != 0) begin
                  errors++;
                  $display("FAIL done got result=%h@%0d pending_pix=%0d expected result=%h@%0d pending_pix=0",
                           bus.result, cyc, pix_q.size(), r.res, r.cyc);
               end
            end
         end
      end
      prev_fin = bus.finished;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (res_q.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (res_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout got pending=%0d expected pending=0", res_q.size());
         res_q.delete();
         pix_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // n is the clipped pixel count; pixels are queued only when plotted=1.
   task automatic send(input logic [31:0] instr, input int hold, input logic [31:0] exp_res,
                       input int n, input int x0, input int y0, input int col, input bit plotted);
      int   e;
      pix_t p;
      res_t r;
      @(negedge clk);
      e = cyc + 1;
      if (plotted) begin
         for (int i = 0; i < n; i++) begin
            p.x = 8'(x0 + i);
            p.y = 7'(y0);
            p.c = 3'(col);
            p.cyc = e + 1 + i;
            pix_q.push_back(p);
         end
      end
      r.res = exp_res;
      r.cyc = (n > 0) ? e + n + 1 : e + 1;
      res_q.push_back(r);
      bus.start       = 1'b1;
      bus.instruction = instr;
      repeat (hold) @(negedge clk);
      bus.start = 1'b0;
      wait_done();
   endtask

   initial begin
      int   e;
      pix_t p;
      checks          = 0;
      errors          = 0;
      prev_fin        = 1'b1;
      reset           = 1'b1;
      bus.start       = 1'b0;
      bus.instruction = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("rst_finished", {31'd0, bus.finished}, 32'd1);
      check("rst_result", bus.result, 32'd0);
      check("rst_vga_x", {24'd0, vga_x}, 32'd0);
      check("rst_vga_y", {25'd0, vga_y}, 32'd0);
      check("rst_vga_colour", {29'd0, vga_colour}, 32'd0);
      check("rst_vga_plot", {31'd0, vga_plot}, 32'd0);
      repeat (5) @(negedge clk);
      check("idle_finished", {31'd0, bus.finished}, 32'd1);

      send(mk(1, 0, 1, 7, 7, 5), 2, 32'd1, 1, 5, 7, 7, 1'b1);
      send(mk(2, 10, 1, 3, 0, 155), 2, 32'd5, 5, 155, 0, 3, 1'b1);
      // NOP with start held long: only one transaction until start drops.
      send(mk(0, 0, 1, 1, 1, 1), 6, 32'd0, 0, 0, 0, 0, 1'b0);
      send(mk(1, 0, 1, 4, 119, 0), 2, 32'd1, 1, 0, 119, 4, 1'b1);
      send(mk(9, 3, 1, 7, 7, 5), 2, 32'hFFFF_FFFF, 0, 0, 0, 0, 1'b0);
      send(mk(1, 0, 1, 7, 7, 200), 2, 32'd0, 0, 0, 0, 0, 1'b0);
      send(mk(1, 0, 1, 2, 120, 3), 2, 32'd0, 0, 0, 0, 0, 1'b0);
      send(mk(2, 0, 1, 2, 3, 3), 2, 32'd0, 0, 0, 0, 0, 1'b0);
      send(mk(2, 3, 0, 6, 5, 10), 2, 32'd3, 3, 10, 5, 6, 1'b0);

      // Long line interrupted by reset sampled at edge E+20.
      @(negedge clk);
      e = cyc + 1;
      for (int i = 0; i < 19; i++) begin
         p.x = 8'(i);
         p.y = 7'd10;
         p.c = 3'd5;
         p.cyc = e + 1 + i;
         pix_q.push_back(p);
      end
      bus.start       = 1'b1;
      bus.instruction = mk(2, 100, 1, 5, 10, 0);
      repeat (2) @(negedge clk);
      bus.start = 1'b0;
      while (cyc < e + 19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid_finished", {31'd0, bus.finished}, 32'd1);
      check("rst_mid_plot", {31'd0, vga_plot}, 32'd0);
      check("rst_mid_result", bus.result, 32'd0);
      check("rst_mid_pix_drained", pix_q.size(), 32'd0);
      repeat (4) @(negedge clk);

      send(mk(1, 0, 1, 2, 119, 159), 2, 32'd1, 1, 159, 119, 2, 1'b1);
      repeat (5) @(negedge clk);

      check("end_pix_queue", pix_q.size(), 32'd0);
      check("end_res_queue", res_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
